// File: rtl/phase_monitor_pkg.sv
// Shared types and constants for the phase-strobe monitor and its decoders.
package phase_monitor_pkg;
   localparam int NPHASE = 5;

   typedef enum logic [1:0] {IDLE, TRACK, ERR} state_t;

   typedef enum logic [1:0] {
      NONE   = 2'd0,
      ONEHOT = 2'd1,
      SEQ    = 2'd2,
      STALL  = 2'd3
   } errcode_t;
endpackage

// File: rtl/phase_monitor_decode.sv
// Combinational strobe classifier: index of the set bit, plus single/multi flags.
module phase_decode
   import phase_monitor_pkg::*;
(
   input  logic [NPHASE-1:0] strobes,
   output logic [2:0]        index,
   output logic              single,
   output logic              multi
);
   always_comb begin
      index = '0;
      for (int k = 0; k < NPHASE; k++)
         if (strobes[k]) index = 3'(k);
   end

   assign single = $onehot(strobes);
   assign multi  = (|strobes) && !single;
endmodule

// File: rtl/phase_monitor.sv
// Decodes the sequencer's phase strobes, checks order/spacing/one-hotness,
// counts completed instructions and latches the first fault.
module phase_monitor
   import phase_monitor_pkg::*;
#(
   parameter int GAP     = 1,
   parameter int TIMEOUT = 4,
   parameter int CW      = 16
)(
   input  logic              clock,
   input  logic              reset,
   input  logic [NPHASE-1:0] phasein,
   input  logic              clearerr,
   output logic [2:0]        phase,
   output logic              phasevalid,
   output logic [CW-1:0]     instrcount,
   output logic              running,
   output logic              error,
   output logic [1:0]        errorcode
);
   localparam int            IW    = $clog2(TIMEOUT + 1);
   localparam logic [IW-1:0] GAPV  = IW'(GAP);
   localparam logic [IW-1:0] TLAST = IW'(TIMEOUT - 1);

   state_t        state;
   errcode_t      code;
   logic [2:0]    expect_ph;
   logic [IW-1:0] idlecnt;
   logic [2:0]    idx;
   logic          single, multi;

   phase_decode u_dec (
      .strobes (phasein),
      .index   (idx),
      .single  (single),
      .multi   (multi)
   );

   assign errorcode = code;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         code       <= NONE;
         expect_ph  <= '0;
         idlecnt    <= '0;
         phase      <= '0;
         phasevalid <= 1'b0;
         instrcount <= '0;
         running    <= 1'b0;
         error      <= 1'b0;
      end else begin
         phasevalid <= 1'b0;
         case (state)
            IDLE: begin
               // Non-zero single strobes are dropped so we relock on the next phase 0
               if (multi) begin
                  state <= ERR; error <= 1'b1; code <= ONEHOT; running <= 1'b0;
               end else if (single && idx == 3'd0) begin
                  state      <= TRACK;
                  phase      <= 3'd0;
                  phasevalid <= 1'b1;
                  expect_ph  <= 3'd1;
                  idlecnt    <= '0;
                  running    <= 1'b1;
               end
            end
            TRACK: begin
               if (multi) begin
                  state <= ERR; error <= 1'b1; code <= ONEHOT; running <= 1'b0;
               end else if (single) begin
                  if (idx != expect_ph || idlecnt != GAPV) begin
                     state <= ERR; error <= 1'b1; code <= SEQ; running <= 1'b0;
                  end else begin
                     phase      <= idx;
                     phasevalid <= 1'b1;
                     expect_ph  <= (idx == 3'd4) ? 3'd0 : idx + 3'd1;
                     idlecnt    <= '0;
                     if (idx == 3'd4) instrcount <= instrcount + CW'(1);
                  end
               end else if (idlecnt == TLAST) begin
                  // Stream stopped: clean halt only if the last strobe closed an instruction
                  running <= 1'b0;
                  idlecnt <= '0;
                  if (expect_ph == 3'd0) state <= IDLE;
                  else begin
                     state <= ERR; error <= 1'b1; code <= STALL;
                  end
               end else begin
                  idlecnt <= idlecnt + IW'(1);
               end
            end
            ERR: begin
               if (clearerr) begin
                  state <= IDLE; error <= 1'b0; code <= NONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_phase_monitor.sv
// Bench for phase_monitor: directed scenarios plus random strobe streams, all
// checked each cycle against a cycle-count reference model.
module tb_phase_monitor;
   localparam int GAP = 1, TIMEOUT = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic [4:0] phasein;
   logic       clearerr;

   logic [2:0]  phase, phase4;
   logic        phasevalid, pv4, running, run4, error, err4;
   logic [15:0] instrcount;
   logic [3:0]  cnt4;
   logic [1:0]  errorcode, code4;

   phase_monitor #(.GAP(GAP), .TIMEOUT(TIMEOUT), .CW(16)) dut (
      .clock(clock), .reset(reset), .phasein(phasein), .clearerr(clearerr),
      .phase(phase), .phasevalid(phasevalid), .instrcount(instrcount),
      .running(running), .error(error), .errorcode(errorcode));

   phase_monitor #(.GAP(GAP), .TIMEOUT(TIMEOUT), .CW(4)) dut4 (
      .clock(clock), .reset(reset), .phasein(phasein), .clearerr(clearerr),
      .phase(phase4), .phasevalid(pv4), .instrcount(cnt4),
      .running(run4), .error(err4), .errorcode(code4));

   always #5 clock = ~clock;

   int nchk = 0, nerr = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: mode 0 unlocked, 1 locked, 2 faulted; since = cycles since last accepted strobe
   int m_mode, m_phase, m_pv, m_cnt, m_run, m_err, m_code, m_nxt, m_since;

   task automatic model_reset();
      m_mode = 0; m_phase = 0; m_pv = 0; m_cnt = 0; m_run = 0;
      m_err = 0; m_code = 0; m_nxt = 0; m_since = 0;
   endtask

   task automatic model_fault(input int c);
      m_mode = 2; m_err = 1; m_code = c; m_run = 0;
   endtask

   task automatic model_step(input logic [4:0] p, input logic c);
      int n, k;
      n = $countones(p);
      k = 0;
      for (int b = 0; b < 5; b++) if (p[b]) k = b;
      m_pv = 0;
      if (m_mode == 0) begin
         if (n > 1) model_fault(1);
         else if (n == 1 && k == 0) begin
            m_mode = 1; m_phase = 0; m_pv = 1; m_nxt = 1; m_since = 0; m_run = 1;
         end
      end else if (m_mode == 1) begin
         if (n > 1) model_fault(1);
         else if (n == 1) begin
            if (k != m_nxt || m_since != GAP) model_fault(2);
            else begin
               m_phase = k; m_pv = 1; m_since = 0;
               m_nxt = (k + 1) % 5;
               if (k == 4) m_cnt++;
            end
         end else begin
            m_since++;
            if (m_since == TIMEOUT) begin
               m_run = 0;
               if (m_nxt == 0) m_mode = 0;
               else model_fault(3);
            end
         end
      end else if (c) begin
         m_mode = 0; m_err = 0; m_code = 0;
      end
   endtask

   task automatic compare_all();
      chk("phase", phase, m_phase);
      chk("phasevalid", phasevalid, m_pv);
      chk("instrcount", instrcount, m_cnt % 65536);
      chk("running", running, m_run);
      chk("error", error, m_err);
      chk("errorcode", errorcode, m_code);
      chk("cw4_count", cnt4, m_cnt % 16);
      chk("cw4_error", {err4, code4, run4}, {m_err[0], m_code[1:0], m_run[0]});
   endtask

   task automatic step(input logic [4:0] p, input logic c);
      phasein = p; clearerr = c;
      model_step(p, c);
      @(posedge clock); #1;
      compare_all();
   endtask

   task automatic instr();
      for (int k = 0; k < 5; k++) begin
         step(5'(1 << k), 1'b0);
         step(5'd0, 1'b0);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(5'd0, 1'b0);
   endtask

   task automatic do_reset();
      #3 reset = 1'b1;
      model_reset();
      #1 compare_all();
      @(posedge clock); #1;
      compare_all();
      reset = 1'b0;
   endtask

   logic [4:0] p;
   logic       c;
   int         r, hold, saved;

   initial begin
      reset = 1'b1; phasein = '0; clearerr = 1'b0;
      model_reset();
      #1 compare_all();
      @(posedge clock); #1;
      reset = 1'b0;

      // nominal: three instructions
      for (int i = 0; i < 3; i++) instr();
      chk("nominal_count", instrcount, 3);
      chk("nominal_running", running, 1);

      // clean halt after phase 4, then relock
      idle(TIMEOUT - 1);
      chk("halt_running", running, 0);
      chk("halt_error", error, 0);
      instr();
      chk("restart_count", instrcount, 4);
      idle(TIMEOUT - 1);

      // mid-instruction stall
      step(5'd1, 0); step(5'd0, 0); step(5'd2, 0); step(5'd0, 0); step(5'd4, 0);
      idle(TIMEOUT);
      chk("stall_code", errorcode, 3);
      step(5'd0, 1);

      // order fault 0,2 and missing gap 0,1
      step(5'd1, 0); step(5'd0, 0); step(5'd4, 0);
      chk("order_code", errorcode, 2);
      step(5'd0, 1);
      step(5'd1, 0); step(5'd2, 0);
      chk("gap_code", errorcode, 2);
      step(5'd0, 1);

      // multi-bit with simultaneous clear, then plain clear
      saved = instrcount;
      step(5'd1, 0); step(5'd0, 0); step(5'b00011, 1);
      chk("multi_error", error, 1);
      chk("multi_code", errorcode, 1);
      step(5'd0, 1);
      chk("clear_error", error, 0);
      chk("clear_count", instrcount, saved);

      // resync: non-zero phase while idle is ignored
      step(5'd8, 0);
      chk("resync_pv", phasevalid, 0);

      // async reset mid-instruction, during phase 3
      step(5'd1, 0); step(5'd0, 0); step(5'd2, 0); step(5'd0, 0);
      step(5'd4, 0); step(5'd0, 0); step(5'd8, 0);
      do_reset();

      // CW=4 wrap
      for (int i = 0; i < 16; i++) instr();
      chk("wrap_cw4", cnt4, 0);
      chk("count16", instrcount, 16);
      idle(TIMEOUT - 1);

      // random streams, mostly legal with injected faults, halts and clears
      hold = 0;
      for (int i = 0; i < 4000; i++) begin
         p = '0;
         c = ($urandom_range(0, 49) == 0);
         r = $urandom_range(0, 99);
         if (m_mode == 2) begin
            c = ($urandom_range(0, 3) == 0);
            if (r < 30) p = 5'($urandom);
         end else if (hold > 0) begin
            hold--;
         end else if (m_mode == 0) begin
            if (r < 40) p = 5'd1;
            else if (r < 50) p = 5'(1 << $urandom_range(1, 4));
            else if (r < 52) p = 5'($urandom);
         end else begin
            if (m_since == GAP) p = 5'(1 << m_nxt);
            if (r < 2) p = 5'($urandom);
            else if (r < 4) p = 5'(1 << $urandom_range(0, 4));
            else if (r < 6 || (m_nxt == 0 && m_since == GAP && r < 12)) begin
               p = '0;
               hold = $urandom_range(1, 6);
            end
         end
         step(p, c);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/phase_monitor.md
# phase_monitor

Receiving end of the phase-strobe interface that the sequencer drives into the datapath. Watches the five one-hot phase strobes and decodes them into a registered phase index. Checks ordering, spacing and one-hotness, counts completed instructions, and tells a legal halt apart from a broken sequence. Sits beside the datapath, with status outputs going to the LED/debug logic.

## Interface
- `GAP`, default 1: exact number of idle cycles required between consecutive strobes, including phase 4 → phase 0.
- `TIMEOUT`, default 4: idle cycles after which the strobe stream is considered stopped; must be > `GAP`.
- `CW`, default 16: width of the instruction counter.
- `clock` in 1: single clock; all state updates on the posedge.
- `reset` in 1: asynchronous, active-high.
- `phasein` in 5: phase strobes, bit k = phase k; nominally one-hot or zero.
- `clearerr` in 1: level; clears the sticky error and returns to IDLE.
- `phase` out 3: index of the last accepted strobe (0..4).
- `phasevalid` out 1: one-cycle pulse when `phase` updates.
- `instrcount` out CW: number of completed 0→4 sequences.
- `running` out 1: locked and strobes arriving.
- `error` out 1: sticky error flag.
- `errorcode` out 2: 0 none, 1 not one-hot, 2 sequence (order or spacing), 3 stopped mid-instruction.

## Operation
- **Strobe decode.** Per cycle, from `phasein`:
  - none: all bits 0;
  - single: exactly one bit set, giving index k;
  - multi: two or more bits set.
- **States:** IDLE, TRACK, ERR.
- **Registers:**
  - `expect` (0..4): next phase expected;
  - `idlecnt` (0..TIMEOUT): idle cycles since the last strobe, saturating.
- **IDLE:**
  - single with k=0 → TRACK; `phase`=0, `phasevalid`=1, `expect`=1, `running`=1.
  - single with k≠0 is ignored (resynchronisation) and state stays IDLE.
  - multi → ERR, code 1.
- **TRACK, strobe present:**
  - multi → ERR, code 1.
  - single where k≠`expect`, or `idlecnt`≠GAP → ERR, code 2.
  - otherwise accept: `phase`=k, `phasevalid`=1, `expect`=(k+1) mod 5, `idlecnt`=0.
  - accepting k=4 increments `instrcount`, which wraps from 2^CW−1 to 0.
- **TRACK, no strobe:** `idlecnt` increments. When it reaches TIMEOUT:
  - if `expect`=0 (halted cleanly after phase 4) → IDLE, `running`=0, no error;
  - otherwise → ERR, code 3, `running`=0.
- **ERR:**
  - `error`=1 and `errorcode` are held; `running`=0; strobes are ignored.
  - `clearerr` → IDLE with `error`=0 and `errorcode`=0. `instrcount` is preserved.
- **`clearerr` in IDLE/TRACK:** no effect.
- **Simultaneous events:** `clearerr` while a new error is detected in the same cycle → the error wins and `errorcode` shows the new code. Only one code is recorded: the first error latched.

## Timing
- Strobe in cycle n → `phase`, `phasevalid`, `instrcount` and `running` update in cycle n+1 (one registered stage).
- Error detected in cycle n → `error` and `errorcode` valid in cycle n+1.
- Timeout: with the last strobe in cycle n, the transition occurs at the edge closing cycle n+TIMEOUT; outputs reflect it in n+TIMEOUT+1.
- With defaults, the nominal stream has strobes every 2 cycles and a 10-cycle instruction, matching the sequencer.
- Reset values, applied at any time including mid-instruction:
  - state IDLE, `phase`=0, `phasevalid`=0, `instrcount`=0, `running`=0, `error`=0, `errorcode`=0;
  - `expect`=0, `idlecnt`=0.
- `phasein` is sampled synchronously; it comes from the same clock domain with no synchroniser.

## Structure
- Shared package holds:
  - `NPHASE`=5;
  - the state typedef (IDLE/TRACK/ERR);
  - the errorcode typedef and its constants (NONE, ONEHOT, SEQ, STALL).
- One sub-module, `phase_decode`: combinational 5-bit → {index[2:0], single, multi}; reused by future datapath-side phase consumers.
- Top level holds the FSM, `idlecnt`, `expect`, `instrcount` and output registers.

## Test plan
- **Nominal:** strobes 1,2,4,8,16 at cycles 0,2,4,6,8, repeated 3 times → `phase` steps 0..4 a cycle after each strobe, `instrcount`=3, `error`=0, `running`=1.
- **Clean halt:** stop after phase 4 → at 4 idle cycles plus 1, `running`=0, `error`=0; a restart with phase 0 relocks and `instrcount` continues at 4.
- **Mid-instruction stall:** stop after phase 2 → `error`=1, `errorcode`=3, `running`=0.
- **Sequence faults:** order 0,2 → `errorcode`=2 the cycle after the phase-2 strobe. In a separate run, phase 1 immediately following phase 0 with no idle cycle → `errorcode`=2.
- **Multi-bit:** `phasein`=5'b00011 in TRACK → `errorcode`=1. Asserting `clearerr` in the same cycle as that fault keeps `error`=1; asserting it alone → IDLE, `error`=0, `instrcount` unchanged.
- **Resync, reset, wrap:**
  - IDLE receiving phase 3 → ignored; `phasevalid` stays 0.
  - Async reset during phase 3 → all outputs return to reset values immediately.
  - With CW=4, 16 instructions → `instrcount` wraps to 0.
